// File: rtl/cmos_pixel_pack_if.sv
`default_nettype none
// ============================================================================
// Module      : cmos_pixel_pack_if
// Description : Packed-word write bus between the pixel packer (master) and
//               the downstream frame buffer writer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface cmos_pixel_pack_if;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        wr_sof;
    logic        wr_eol;

    modport master (
        output wr_en,
        output wr_data,
        output wr_sof,
        output wr_eol
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        input  wr_sof,
        input  wr_eol
    );
endinterface
`default_nettype wire

// File: rtl/cmos_pixel_pack.sv
`default_nettype none
// ============================================================================
// Module      : cmos_pixel_pack
// Description : Packs 8-bit CMOS capture bytes into 32-bit words (first byte
//               in [7:0]), flags start of frame / end of line, counts lines
//               and pulses frame_done when the frame closes.
//               Optional macro PACK_CHECK_EN builds the sticky line-length
//               and line-count checks; without it line_err/frame_err are 0.
// Revision    : 1.0 - initial release
// ============================================================================
module cmos_pixel_pack #(
    parameter int IMG_HDISP = 1280,
    parameter int IMG_VDISP = 720
) (
    input  wire logic         cmos_pclk,
    input  wire logic         rst_n,
    input  wire logic         cmos_frame_vsync,
    input  wire logic         cmos_frame_href,
    input  wire logic [7:0]   cmos_frame_data,
    cmos_pixel_pack_if.master wr_bus,
    output logic              frame_done,
    output logic [11:0]       line_cnt,
    output logic              line_err,
    output logic              frame_err
);

    localparam logic [1:0] c_WAIT_FRAME = 2'd0;
    localparam logic [1:0] c_ACTIVE     = 2'd1;
    localparam logic [1:0] c_FLUSH      = 2'd2;

    logic [1:0]  r_state;
    logic        r_vsync_d;
    logic        r_href_d;
    logic [11:0] r_byte_cnt;
    logic [23:0] r_lanes;
    logic        r_wr_en;
    logic [31:0] r_wr_data;
    logic        r_wr_sof;
    logic        r_eol_flush;
    logic        r_sof_pending;
    logic        r_end_frame;
    logic        r_frame_done;
    logic [11:0] r_line_cnt;

    logic        w_href_q;
    logic        w_vsync_rise;
    logic        w_vsync_fall;
    logic        w_line_end;
    logic        w_partial;
    logic        w_frame_end;
    logic [11:0] w_line_cnt_inc;
    logic [11:0] w_byte_cnt_inc;

    // href only counts while vsync is high
    assign w_href_q       = cmos_frame_href & cmos_frame_vsync;
    assign w_vsync_rise   = ~r_vsync_d & cmos_frame_vsync;
    assign w_vsync_fall   = r_vsync_d & ~cmos_frame_vsync;
    // A vsync fall during href also drops w_href_q, so it is seen as a line end
    assign w_line_end     = (r_state == c_ACTIVE) & r_href_d & ~w_href_q;
    assign w_partial      = (r_byte_cnt[1:0] != 2'd0);
    assign w_frame_end    = ((r_state == c_ACTIVE) & w_vsync_fall & ~(w_line_end & w_partial))
                          | ((r_state == c_FLUSH) & (r_end_frame | w_vsync_fall));
    assign w_line_cnt_inc = (r_line_cnt == 12'hFFF) ? r_line_cnt : r_line_cnt + 12'd1;
    assign w_byte_cnt_inc = (r_byte_cnt == 12'hFFF) ? r_byte_cnt : r_byte_cnt + 12'd1;

    // Capture FSM: byte packing, line/frame framing and registered outputs
    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_WAIT_FRAME;
            // Held high so a vsync already high at release is not a rising edge
            r_vsync_d     <= 1'b1;
            r_href_d      <= 1'b0;
            r_byte_cnt    <= 12'd0;
            r_lanes       <= 24'd0;
            r_wr_en       <= 1'b0;
            r_wr_data     <= 32'd0;
            r_wr_sof      <= 1'b0;
            r_eol_flush   <= 1'b0;
            r_sof_pending <= 1'b0;
            r_end_frame   <= 1'b0;
            r_frame_done  <= 1'b0;
            r_line_cnt    <= 12'd0;
        end else begin
            r_vsync_d    <= cmos_frame_vsync;
            r_href_d     <= (r_state != c_WAIT_FRAME) & w_href_q;
            r_wr_en      <= 1'b0;
            r_wr_sof     <= 1'b0;
            r_eol_flush  <= 1'b0;
            r_frame_done <= w_frame_end;

            case (r_state)
                c_WAIT_FRAME: begin
                    if (w_vsync_rise) begin
                        r_state       <= c_ACTIVE;
                        r_line_cnt    <= 12'd0;
                        r_byte_cnt    <= 12'd0;
                        r_sof_pending <= 1'b1;
                        r_end_frame   <= 1'b0;
                    end
                end
                c_ACTIVE: begin
                    if (w_line_end) begin
                        r_line_cnt <= w_line_cnt_inc;
                        r_byte_cnt <= 12'd0;
                        if (w_partial) begin
                            // Unused lanes were zeroed when lane 0 was written
                            r_wr_en       <= 1'b1;
                            r_wr_data     <= {8'h00, r_lanes};
                            r_wr_sof      <= r_sof_pending;
                            r_sof_pending <= 1'b0;
                            r_eol_flush   <= 1'b1;
                            r_end_frame   <= w_vsync_fall;
                            r_state       <= c_FLUSH;
                        end else if (w_vsync_fall) begin
                            r_state <= c_WAIT_FRAME;
                        end
                    end else if (w_vsync_fall) begin
                        r_state <= c_WAIT_FRAME;
                    end
                end
                c_FLUSH: begin
                    r_state <= w_frame_end ? c_WAIT_FRAME : c_ACTIVE;
                end
                default: begin
                    r_state <= c_WAIT_FRAME;
                end
            endcase

            // Byte packing runs in ACTIVE and FLUSH (a new line may start right away)
            if ((r_state != c_WAIT_FRAME) && w_href_q) begin
                r_byte_cnt <= w_byte_cnt_inc;
                case (r_byte_cnt[1:0])
                    2'd0:    r_lanes        <= {16'h0000, cmos_frame_data};
                    2'd1:    r_lanes[15:8]  <= cmos_frame_data;
                    2'd2:    r_lanes[23:16] <= cmos_frame_data;
                    default: begin
                        r_wr_en       <= 1'b1;
                        r_wr_data     <= {cmos_frame_data, r_lanes};
                        r_wr_sof      <= r_sof_pending;
                        r_sof_pending <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign wr_bus.wr_en   = r_wr_en;
    assign wr_bus.wr_data = r_wr_data;
    assign wr_bus.wr_sof  = r_wr_sof;
    // A full word issued on the last byte learns it ends the line only in the
    // following cycle, when href has dropped; flagged combinationally then.
    assign wr_bus.wr_eol  = r_eol_flush
                          | (r_wr_en & (r_state == c_ACTIVE) & r_href_d & ~w_href_q);
    assign frame_done     = r_frame_done;
    assign line_cnt       = r_line_cnt;

`ifdef PACK_CHECK_EN
    localparam logic [11:0] c_HDISP = 12'(IMG_HDISP);
    localparam logic [11:0] c_VDISP = 12'(IMG_VDISP);

    logic [11:0] w_lines_final;
    logic        r_line_err;
    logic        r_frame_err;

    // Line count including a line that ends on the same edge as the frame
    assign w_lines_final = w_line_end ? w_line_cnt_inc : r_line_cnt;

    // Sticky geometry checks, cleared only by reset
    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_err  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_line_end && (r_byte_cnt != c_HDISP)) begin
                r_line_err <= 1'b1;
            end
            if (w_frame_end && (w_lines_final != c_VDISP)) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    assign line_err  = r_line_err;
    assign frame_err = r_frame_err;
`else
    assign line_err  = 1'b0;
    assign frame_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmos_pixel_pack.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmos_pixel_pack
// Description : Directed self-checking bench for cmos_pixel_pack using a
//               reduced 8-byte x 2-line frame geometry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmos_pixel_pack;

`ifdef PACK_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        cmos_pclk = 1'b0;
    logic        rst_n     = 1'b0;
    logic        vsync     = 1'b0;
    logic        href      = 1'b0;
    logic [7:0]  data      = 8'h00;
    logic        frame_done;
    logic [11:0] line_cnt;
    logic        line_err;
    logic        frame_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] q_data[$];
    logic        q_sof[$];
    logic        q_eol[$];
    int          n_done = 0;

    cmos_pixel_pack_if wr_bus ();

    cmos_pixel_pack #(
        .IMG_HDISP (8),
        .IMG_VDISP (2)
    ) u_dut (
        .cmos_pclk        (cmos_pclk),
        .rst_n            (rst_n),
        .cmos_frame_vsync (vsync),
        .cmos_frame_href  (href),
        .cmos_frame_data  (data),
        .wr_bus           (wr_bus),
        .frame_done       (frame_done),
        .line_cnt         (line_cnt),
        .line_err         (line_err),
        .frame_err        (frame_err)
    );

    always #5 cmos_pclk = ~cmos_pclk;

    // Record every emitted word and frame_done pulse mid-cycle
    always @(negedge cmos_pclk) begin
        if (wr_bus.wr_en === 1'b1) begin
            q_data.push_back(wr_bus.wr_data);
            q_sof.push_back(wr_bus.wr_sof);
            q_eol.push_back(wr_bus.wr_eol);
        end
        if (frame_done === 1'b1) n_done++;
    end

    task automatic tick();
        @(posedge cmos_pclk);
        #1;
    endtask

    task automatic clear_mon();
        q_data.delete();
        q_sof.delete();
        q_eol.delete();
        n_done = 0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'h00;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic start_frame();
        vsync = 1'b1; href = 1'b0;
        tick(); tick();
    endtask

    task automatic send_line(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            data = base + 8'(i); href = 1'b1;
            tick();
        end
        href = 1'b0; data = 8'h00;
        tick(); tick(); tick();
    endtask

    task automatic end_frame();
        vsync = 1'b0; href = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vsync = 1'b0; href = 1'b0;
        tick(); tick();
        @(negedge cmos_pclk);
        total++; if (wr_bus.wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en: got %b want 0", wr_bus.wr_en); end
        total++; if (wr_bus.wr_data !== 32'd0) begin bad++; $display("FAIL rst_wr_data: got %h want 0", wr_bus.wr_data); end
        total++; if ({wr_bus.wr_sof, wr_bus.wr_eol, frame_done} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b want 000", {wr_bus.wr_sof, wr_bus.wr_eol, frame_done}); end
        total++; if ({line_cnt, line_err, frame_err} !== 14'd0) begin bad++; $display("FAIL rst_status: got %h/%b/%b want 0", line_cnt, line_err, frame_err); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_word();
        apply_reset(); clear_mon();
        start_frame();
        for (int i = 0; i < 4; i++) begin
            data = 8'(i + 1); href = 1'b1;
            tick();
            if (i == 2) begin
                @(negedge cmos_pclk);
                total++; if (wr_bus.wr_en !== 1'b0) begin bad++; $display("FAIL sw_early: got wr_en=%b want 0", wr_bus.wr_en); end
            end
        end
        href = 1'b0; data = 8'h00;
        @(negedge cmos_pclk);
        total++; if (wr_bus.wr_en !== 1'b1) begin bad++; $display("FAIL sw_latency: got wr_en=%b want 1", wr_bus.wr_en); end
        total++; if (wr_bus.wr_data !== 32'h04030201) begin bad++; $display("FAIL sw_data: got %h want 04030201", wr_bus.wr_data); end
        total++; if (wr_bus.wr_sof !== 1'b1) begin bad++; $display("FAIL sw_sof: got %b want 1", wr_bus.wr_sof); end
        total++; if (wr_bus.wr_eol !== 1'b1) begin bad++; $display("FAIL sw_eol: got %b want 1", wr_bus.wr_eol); end
        tick();
        @(negedge cmos_pclk);
        total++; if (wr_bus.wr_en !== 1'b0) begin bad++; $display("FAIL sw_no_extra: got wr_en=%b want 0", wr_bus.wr_en); end
        total++; if (line_cnt !== 12'd1) begin bad++; $display("FAIL sw_line_cnt: got %0d want 1", line_cnt); end
        vsync = 1'b0;
        tick();
        @(negedge cmos_pclk);
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL sw_done: got %b want 1", frame_done); end
        tick();
        @(negedge cmos_pclk);
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL sw_done_len: got %b want 0", frame_done); end
        total++; if (line_err !== CHK) begin bad++; $display("FAIL sw_line_err: got %b want %b", line_err, CHK); end
        total++; if (frame_err !== CHK) begin bad++; $display("FAIL sw_frame_err: got %b want %b", frame_err, CHK); end
    endtask

    task automatic test_full_frame();
        logic [31:0] exp_d [4] = '{32'h23222120, 32'h27262524, 32'h43424140, 32'h47464544};
        logic        exp_s [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic        exp_e [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        apply_reset(); clear_mon();
        start_frame();
        send_line(8'h20, 8);
        send_line(8'h40, 8);
        end_frame();
        total++; if (q_data.size() != 4) begin bad++; $display("FAIL ff_words: got %0d want 4", q_data.size()); end
        for (int i = 0; i < 4; i++) begin
            total++; if (q_data[i] !== exp_d[i]) begin bad++; $display("FAIL ff_data[%0d]: got %h want %h", i, q_data[i], exp_d[i]); end
            total++; if ({q_sof[i], q_eol[i]} !== {exp_s[i], exp_e[i]}) begin bad++; $display("FAIL ff_flags[%0d]: got %b want %b", i, {q_sof[i], q_eol[i]}, {exp_s[i], exp_e[i]}); end
        end
        total++; if (n_done != 1) begin bad++; $display("FAIL ff_done_cnt: got %0d want 1", n_done); end
        total++; if (line_cnt !== 12'd2) begin bad++; $display("FAIL ff_line_cnt: got %0d want 2", line_cnt); end
        total++; if ({line_err, frame_err} !== 2'b00) begin bad++; $display("FAIL ff_errs: got %b want 00", {line_err, frame_err}); end
    endtask

    task automatic test_partial_line();
        apply_reset(); clear_mon();
        start_frame();
        send_line(8'h11, 6);
        end_frame();
        total++; if (q_data.size() != 2) begin bad++; $display("FAIL pl_words: got %0d want 2", q_data.size()); end
        total++; if (q_data[0] !== 32'h14131211 || q_eol[0] !== 1'b0) begin bad++; $display("FAIL pl_word0: got %h eol=%b want 14131211 eol=0", q_data[0], q_eol[0]); end
        total++; if (q_data[1] !== 32'h00001615 || q_eol[1] !== 1'b1) begin bad++; $display("FAIL pl_word1: got %h eol=%b want 00001615 eol=1", q_data[1], q_eol[1]); end
        total++; if (line_err !== CHK) begin bad++; $display("FAIL pl_line_err: got %b want %b", line_err, CHK); end
    endtask

    task automatic test_vsync_fall_in_href();
        apply_reset(); clear_mon();
        start_frame();
        data = 8'hAA; href = 1'b1; tick();
        data = 8'hBB; tick();
        vsync = 1'b0; data = 8'hCC;
        tick();
        @(negedge cmos_pclk);
        total++; if (wr_bus.wr_en !== 1'b1 || wr_bus.wr_data !== 32'h0000BBAA) begin bad++; $display("FAIL vf_word: got en=%b %h want en=1 0000bbaa", wr_bus.wr_en, wr_bus.wr_data); end
        total++; if ({wr_bus.wr_sof, wr_bus.wr_eol, frame_done} !== 3'b110) begin bad++; $display("FAIL vf_flags: got %b want 110", {wr_bus.wr_sof, wr_bus.wr_eol, frame_done}); end
        href = 1'b0;
        tick();
        @(negedge cmos_pclk);
        total++; if ({wr_bus.wr_en, frame_done} !== 2'b01) begin bad++; $display("FAIL vf_done: got %b want 01", {wr_bus.wr_en, frame_done}); end
        tick(); tick();
        total++; if (n_done != 1 || q_data.size() != 1) begin bad++; $display("FAIL vf_counts: got done=%0d words=%0d want 1/1", n_done, q_data.size()); end
        total++; if (line_cnt !== 12'd1) begin bad++; $display("FAIL vf_line_cnt: got %0d want 1", line_cnt); end
    endtask

    task automatic test_reset_mid_line();
        apply_reset(); clear_mon();
        start_frame();
        data = 8'h01; href = 1'b1; tick();
        data = 8'h02; tick();
        rst_n = 1'b0;
        @(negedge cmos_pclk);
        total++; if ({wr_bus.wr_en, line_cnt} !== 13'd0) begin bad++; $display("FAIL rm_in_reset: got %b/%0d want 0/0", wr_bus.wr_en, line_cnt); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data = 8'(8'h30 + i); tick();
        end
        href = 1'b0; tick(); tick();
        total++; if (q_data.size() != 0) begin bad++; $display("FAIL rm_no_word: got %0d words want 0", q_data.size()); end
        end_frame();
        start_frame();
        send_line(8'h51, 4);
        end_frame();
        total++; if (q_data.size() != 1 || q_data[0] !== 32'h54535251) begin bad++; $display("FAIL rm_resume: got %0d words first=%h want 1 54535251", q_data.size(), q_data[0]); end
        total++; if (q_sof[0] !== 1'b1) begin bad++; $display("FAIL rm_sof: got %b want 1", q_sof[0]); end
    endtask

    task automatic test_no_vsync();
        apply_reset(); clear_mon();
        send_line(8'h61, 8);
        send_line(8'h71, 5);
        total++; if (q_data.size() != 0 || n_done != 0) begin bad++; $display("FAIL nv_quiet: got words=%0d done=%0d want 0/0", q_data.size(), n_done); end
        total++; if (line_cnt !== 12'd0) begin bad++; $display("FAIL nv_line_cnt: got %0d want 0", line_cnt); end
    endtask

    task automatic test_short_frame();
        apply_reset(); clear_mon();
        start_frame();
        send_line(8'h80, 8);
        end_frame();
        total++; if (line_err !== 1'b0) begin bad++; $display("FAIL sf_line_err: got %b want 0", line_err); end
        total++; if (frame_err !== CHK) begin bad++; $display("FAIL sf_frame_err: got %b want %b", frame_err, CHK); end
    endtask

    task automatic test_back_to_back();
        apply_reset(); clear_mon();
        start_frame();
        send_line(8'h90, 8);
        send_line(8'hA0, 8);
        end_frame();
        total++; if (line_cnt !== 12'd2) begin bad++; $display("FAIL bb_hold: got %0d want 2", line_cnt); end
        clear_mon();
        start_frame();
        total++; if (line_cnt !== 12'd0) begin bad++; $display("FAIL bb_clear: got %0d want 0", line_cnt); end
        send_line(8'hB0, 8);
        total++; if (q_data.size() != 2 || q_sof[0] !== 1'b1 || q_sof[1] !== 1'b0) begin bad++; $display("FAIL bb_sof: got %0d words sof=%b%b want 2 10", q_data.size(), q_sof[0], q_sof[1]); end
        total++; if (q_data[1] !== 32'hB7B6B5B4) begin bad++; $display("FAIL bb_data: got %h want b7b6b5b4", q_data[1]); end
        send_line(8'hC0, 8);
        end_frame();
        total++; if (n_done != 1 || {line_err, frame_err} !== 2'b00) begin bad++; $display("FAIL bb_end: got done=%0d errs=%b want 1 00", n_done, {line_err, frame_err}); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_full_frame();
        test_partial_line();
        test_vsync_fall_in_href();
        test_reset_mid_line();
        test_no_vsync();
        test_short_frame();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
